seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display bank. Holds a frame buffer of hex digits plus per-digit decimal points, double-buffered so updates land only at frame boundaries, and scans one digit per slot with a programmable blanking gap against ghosting. Sits between the stopwatch/counter datapath and the board pins, replacing per-digit static decoding.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_hex_glyph.sv | 31 +++
 rtl/seg7_scan_driver.sv | 127 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low [a..g] glyphs,
// segment bit positions and the all-off pattern.
package seg7_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [6:0] GLYPH_OFF = 7'h7F;

    // Bit 6 = a ... bit 0 = g, 0 = segment lit
    localparam logic [6:0] GLYPH_0 = 7'h01;
    localparam logic [6:0] GLYPH_1 = 7'h4F;
    localparam logic [6:0] GLYPH_2 = 7'h12;
    localparam logic [6:0] GLYPH_3 = 7'h06;
    localparam logic [6:0] GLYPH_4 = 7'h4C;
    localparam logic [6:0] GLYPH_5 = 7'h24;
    localparam logic [6:0] GLYPH_6 = 7'h20;
    localparam logic [6:0] GLYPH_7 = 7'h0F;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h04;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h60;
    localparam logic [6:0] GLYPH_C = 7'h31;
    localparam logic [6:0] GLYPH_D = 7'h42;
    localparam logic [6:0] GLYPH_E = 7'h30;
    localparam logic [6:0] GLYPH_F = 7'h38;

endpackage

// File: rtl/seg7_hex_glyph.sv
// Combinational hex nibble to active-low [a..g] segment pattern.
module seg7_hex_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = GLYPH_OFF;
        unique case (hex_i)
            4'h0: glyph_o = GLYPH_0;
            4'h1: glyph_o = GLYPH_1;
            4'h2: glyph_o = GLYPH_2;
            4'h3: glyph_o = GLYPH_3;
            4'h4: glyph_o = GLYPH_4;
            4'h5: glyph_o = GLYPH_5;
            4'h6: glyph_o = GLYPH_6;
            4'h7: glyph_o = GLYPH_7;
            4'h8: glyph_o = GLYPH_8;
            4'h9: glyph_o = GLYPH_9;
            4'hA: glyph_o = GLYPH_A;
            4'hB: glyph_o = GLYPH_B;
            4'hC: glyph_o = GLYPH_C;
            4'hD: glyph_o = GLYPH_D;
            4'hE: glyph_o = GLYPH_E;
            4'hF: glyph_o = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with double-buffered frame data.
// Define SEG7_LZ_BLANK_EN to enable leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dots,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = 5 * NUM_DIGITS;

    logic [SW-1:0]         slot_q, slot_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         stage_q, stage_d, shadow_q, shadow_d;
    logic                  pend_q, pend_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;

    logic       slot_last, idx_last, boundary;
    logic [3:0] cur_hex;
    logic       cur_dot;
    logic [6:0] glyph;
    logic       suppress;

    assign slot_last = (slot_q == SW'(SLOT_CYCLES - 1));
    assign idx_last  = (idx_q == IW'(NUM_DIGITS - 1));
    assign boundary  = en && slot_last && idx_last;

    always_comb begin
        slot_d = slot_q;
        idx_d  = idx_q;
        if (en) begin
            if (slot_last) begin
                slot_d = '0;
                idx_d  = idx_last ? '0 : idx_q + IW'(1);
            end else begin
                slot_d = slot_q + SW'(1);
            end
        end
    end

    // A load on the boundary cycle still hands the old staging word to the
    // shadow; the new word waits one more frame with pending kept set.
    always_comb begin
        stage_d  = load ? {digits, dots} : stage_q;
        shadow_d = (boundary && pend_q) ? stage_q : shadow_q;
        pend_d   = load ? 1'b1 : (boundary ? 1'b0 : pend_q);
    end

    assign cur_hex = shadow_q[NUM_DIGITS + 4*int'(idx_q) +: 4];
    assign cur_dot = shadow_q[idx_q];

    seg7_hex_glyph u_glyph (
        .hex_i   (cur_hex),
        .glyph_o (glyph)
    );

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;

    // lz[i]: digit i and everything above it are zero; digit 0 never blanks
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz       = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero && (shadow_q[NUM_DIGITS + 4*i +: 4] == 4'h0);
            lz[i]    = all_zero;
        end
    end

    assign suppress = lz[idx_q];
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        seg_d  = SEG_OFF;
        an_d   = '1;
        tick_d = boundary;
        if (en && int'(slot_q) >= BLANK_CYCLES) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = {suppress ? GLYPH_OFF : glyph, ~cur_dot};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            idx_q    <= '0;
            stage_q  <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            seg_q    <= SEG_OFF;
            an_q     <= '1;
            tick_q   <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            idx_q    <= idx_d;
            stage_q  <= stage_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dots = '0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef SEG7_LZ_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .SLOT_CYCLES  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .digits     (digits),
        .dots       (dots),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // cyc = number of enabled, non-reset edges since the last reset
    task automatic tick();
        if (rst) cyc = 0;
        else if (en) cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int n);
        for (int g = 0; g < 4000 && cyc < n; g++) tick();
        if (cyc < n) chk("step_bound", cyc, n);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        digits = d;
        dots   = p;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic chk_lit(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
        chk({tag, "_an"}, an, exp_an);
        chk({tag, "_seg"}, seg, exp_seg);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_seg", seg, 8'hFF);
        chk("rst_an", an, 4'hF);
        chk("rst_tick", frame_tick, 1'b0);

        rst = 1'b0;
        en  = 1'b1;
        tick();
        chk("blank0_seg", seg, 8'hFF);
        tick();
        chk_lit("blank1", 4'hF, 8'hFF);
        tick();
        chk_lit("first_lit", 4'b1110, 8'h03);

        do_load(16'h1234, 4'b0100);
        step_to(19);
        chk_lit("old_d2", 4'b1011, 8'h03);
        step_to(31);
        chk("tick_pre", frame_tick, 1'b0);
        step_to(32);
        chk("tick_f1", frame_tick, 1'b1);
        step_to(35);
        chk_lit("d0_4", 4'b1110, 8'h99);
        step_to(43);
        chk_lit("d1_3", 4'b1101, 8'h0D);
        step_to(51);
        chk_lit("d2_2dp", 4'b1011, 8'h24);
        step_to(59);
        chk_lit("d3_1", 4'b0111, 8'h9F);
        step_to(64);
        chk("tick_f2", frame_tick, 1'b1);

        // pending 5678, then a load landing exactly on the boundary
        step_to(70);
        do_load(16'h5678, 4'b0000);
        step_to(95);
        do_load(16'hABCD, 4'b0000);
        chk("tick_f3", frame_tick, 1'b1);
        step_to(99);
        chk_lit("bnd_old_d0", 4'b1110, 8'h01);
        step_to(123);
        chk_lit("bnd_old_d3", 4'b0111, 8'h49);
        step_to(128);
        chk("tick_f4", frame_tick, 1'b1);
        step_to(131);
        chk_lit("bnd_new_d0", 4'b1110, 8'h85);
        step_to(155);
        chk_lit("bnd_new_d3", 4'b0111, 8'h11);

        // pause mid-slot
        step_to(164);
        en = 1'b0;
        tick();
        chk_lit("pause_a", 4'hF, 8'hFF);
        tick();
        tick();
        tick();
        tick();
        chk_lit("pause_b", 4'hF, 8'hFF);
        chk("pause_tick", frame_tick, 1'b0);
        en = 1'b1;
        step_to(165);
        chk_lit("resume", 4'b1110, 8'h85);
        step_to(169);
        chk_lit("resume_blank", 4'hF, 8'hFF);
        step_to(171);
        chk_lit("resume_d1", 4'b1101, 8'h63);

        // reset mid-frame with a pending load
        step_to(175);
        do_load(16'h1111, 4'b1111);
        step_to(180);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_lit("mid_rst", 4'hF, 8'hFF);
        tick();
        tick();
        tick();
        chk_lit("rst_restart", 4'b1110, 8'h03);
        step_to(32);
        chk("rst_tick_f1", frame_tick, 1'b1);
        step_to(35);
        chk_lit("rst_discard", 4'b1110, 8'h03);

        // zeros: plain glyphs or leading-zero suppression
        step_to(40);
        do_load(16'h0050, 4'b0000);
        step_to(67);
        chk_lit("z_d0", 4'b1110, 8'h03);
        step_to(70);
        do_load(16'h0000, 4'b1000);
        step_to(75);
        chk_lit("z_d1", 4'b1101, 8'h49);
        step_to(83);
        chk_lit("z_d2", 4'b1011, LZ ? 8'hFF : 8'h03);
        step_to(91);
        chk_lit("z_d3", 4'b0111, LZ ? 8'hFF : 8'h03);
        step_to(99);
        chk_lit("az_d0", 4'b1110, 8'h03);
        step_to(107);
        chk_lit("az_d1", 4'b1101, LZ ? 8'hFF : 8'h03);
        step_to(123);
        chk_lit("az_d3dp", 4'b0111, LZ ? 8'hFE : 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
